// File: rtl/blocpu_pkg.sv
// Shared definitions for the blocpu core and its program loader.
// The CHK state only exists when BLOCPU_LOADER_CHECKSUM_EN is defined.
package blocpu_pkg;

  localparam int CPU_WIDTH_DEFAULT         = 8;
  localparam int INSTRUCTION_WIDTH_DEFAULT = 12;

  // Header byte count field is always two bytes wide.
  localparam int HDR_COUNT_WIDTH = 16;

  typedef enum logic [3:0] {
    ST_HDR_HI    = 4'd0,
    ST_HDR_LO    = 4'd1,
    ST_CORE_RST  = 4'd2,
    ST_INS_HI    = 4'd3,
    ST_INS_LO    = 4'd4,
    ST_WR_SETUP  = 4'd5,
    ST_WR_STROBE = 4'd6,
`ifdef BLOCPU_LOADER_CHECKSUM_EN
    ST_CHK       = 4'd7,
`endif
    ST_START     = 4'd8,
    ST_DONE      = 4'd9,
    ST_ERROR     = 4'd10
  } loader_state_e;

  // True in the states where the loader consumes a host byte.
  function automatic logic state_accepts_byte(input loader_state_e s);
`ifdef BLOCPU_LOADER_CHECKSUM_EN
    return (s == ST_HDR_HI) || (s == ST_HDR_LO) || (s == ST_INS_HI) ||
           (s == ST_INS_LO) || (s == ST_CHK);
`else
    return (s == ST_HDR_HI) || (s == ST_HDR_LO) || (s == ST_INS_HI) ||
           (s == ST_INS_LO);
`endif
  endfunction

endpackage

// File: rtl/blocpu_loader_pulse.sv
// Counter-based pulse generator: start_i launches a pulse that stays high
// for exactly CYCLES clock cycles; last_o marks the final high cycle.
module blocpu_loader_pulse #(
  parameter int CYCLES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  output logic pulse_o,
  output logic last_o
);

  localparam int CW = $clog2(CYCLES + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Reload on start, otherwise count down to zero and stop there.
  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = CW'(CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Down-counter register, cleared by reset so no pulse is in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign pulse_o = (cnt_q != '0);
  assign last_o  = (cnt_q == CW'(1));

endmodule

// File: rtl/blocpu_loader.sv
// Byte-stream program loader for the blocpu core. Accepts a big-endian
// 16-bit instruction count followed by (high, low) instruction byte pairs,
// pulses the core reset, writes each instruction with a clean
// setup/strobe sequence, then starts the core.
// Optional feature macro: BLOCPU_LOADER_CHECKSUM_EN adds a trailing XOR
// checksum byte checked in the CHK state.
module blocpu_loader
  import blocpu_pkg::*;
#(
  parameter int CPU_WIDTH          = CPU_WIDTH_DEFAULT,
  parameter int INSTRUCTION_WIDTH  = INSTRUCTION_WIDTH_DEFAULT,
  parameter int RESET_PULSE_CYCLES = 2
) (
  input  logic                         in_clock,
  input  logic                         in_reset,
  input  logic [7:0]                   in_byte,
  input  logic                         in_byte_valid,
  output logic                         out_byte_ready,
  output logic [INSTRUCTION_WIDTH-1:0] out_instruction,
  output logic [2*CPU_WIDTH-1:0]       out_instruction_address,
  output logic                         out_instruction_write,
  output logic                         out_core_reset,
  output logic                         out_core_running,
  output logic                         out_busy,
  output logic                         out_done,
  output logic                         out_error
);

  localparam int AW = 2 * CPU_WIDTH;

  loader_state_e                state_q, state_d;
  logic [HDR_COUNT_WIDTH-1:0]   count_q, count_d;
  logic [AW-1:0]                addr_q, addr_d;
  logic [AW-1:0]                wrAddr_q, wrAddr_d;
  logic [3:0]                   insHi_q, insHi_d;
  logic [INSTRUCTION_WIDTH-1:0] instr_q, instr_d;
`ifdef BLOCPU_LOADER_CHECKSUM_EN
  logic [7:0]                   chkSum_q, chkSum_d;
`endif

  logic          byteReady;
  logic          byteAccept;
  logic          pulseStart;
  logic          pulseActive;
  logic          pulseLast;
  logic [AW-1:0] lastAddr;

  assign byteReady  = state_accepts_byte(state_q);
  assign byteAccept = byteReady && in_byte_valid;
  assign lastAddr   = AW'(count_q - HDR_COUNT_WIDTH'(1));

  blocpu_loader_pulse #(
    .CYCLES(RESET_PULSE_CYCLES)
  ) u_core_reset_pulse (
    .clk_i  (in_clock),
    .rst_i  (in_reset),
    .start_i(pulseStart),
    .pulse_o(pulseActive),
    .last_o (pulseLast)
  );

  // Loader sequencing: header parse, core reset, per-instruction write, start.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    addr_d     = addr_q;
    wrAddr_d   = wrAddr_q;
    insHi_d    = insHi_q;
    instr_d    = instr_q;
    pulseStart = 1'b0;
`ifdef BLOCPU_LOADER_CHECKSUM_EN
    chkSum_d   = chkSum_q;
`endif
    case (state_q)
      ST_HDR_HI: begin
        if (byteAccept) begin
          count_d = {in_byte, 8'h00};
`ifdef BLOCPU_LOADER_CHECKSUM_EN
          chkSum_d = in_byte;
`endif
          state_d = ST_HDR_LO;
        end
      end
      ST_HDR_LO: begin
        if (byteAccept) begin
          count_d = {count_q[15:8], in_byte};
`ifdef BLOCPU_LOADER_CHECKSUM_EN
          chkSum_d = chkSum_q ^ in_byte;
`endif
          if ({count_q[15:8], in_byte} == '0) begin
            state_d = ST_ERROR;
          end else begin
            addr_d     = '0;
            pulseStart = 1'b1;
            state_d    = ST_CORE_RST;
          end
        end
      end
      ST_CORE_RST: begin
        if (pulseLast) begin
          state_d = ST_INS_HI;
        end
      end
      ST_INS_HI: begin
        if (byteAccept) begin
          if (in_byte[7:4] != 4'h0) begin
            state_d = ST_ERROR;
          end else begin
            insHi_d = in_byte[3:0];
`ifdef BLOCPU_LOADER_CHECKSUM_EN
            chkSum_d = chkSum_q ^ in_byte;
`endif
            state_d = ST_INS_LO;
          end
        end
      end
      ST_INS_LO: begin
        if (byteAccept) begin
          instr_d  = INSTRUCTION_WIDTH'({insHi_q, in_byte});
          wrAddr_d = addr_q;
`ifdef BLOCPU_LOADER_CHECKSUM_EN
          chkSum_d = chkSum_q ^ in_byte;
`endif
          state_d  = ST_WR_SETUP;
        end
      end
      ST_WR_SETUP: begin
        state_d = ST_WR_STROBE;
      end
      ST_WR_STROBE: begin
        if (addr_q == lastAddr) begin
`ifdef BLOCPU_LOADER_CHECKSUM_EN
          state_d = ST_CHK;
`else
          state_d = ST_START;
`endif
        end else begin
          addr_d  = addr_q + AW'(1);
          state_d = ST_INS_HI;
        end
      end
`ifdef BLOCPU_LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (byteAccept) begin
          state_d = (in_byte == chkSum_q) ? ST_START : ST_ERROR;
        end
      end
`endif
      ST_START: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_HDR_HI;
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_ERROR;
      end
    endcase
  end

  // State and datapath registers; reset aborts any load immediately.
  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      state_q  <= ST_HDR_HI;
      count_q  <= '0;
      addr_q   <= '0;
      wrAddr_q <= '0;
      insHi_q  <= '0;
      instr_q  <= '0;
`ifdef BLOCPU_LOADER_CHECKSUM_EN
      chkSum_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
      wrAddr_q <= wrAddr_d;
      insHi_q  <= insHi_d;
      instr_q  <= instr_d;
`ifdef BLOCPU_LOADER_CHECKSUM_EN
      chkSum_q <= chkSum_d;
`endif
    end
  end

  assign out_byte_ready          = byteReady;
  assign out_instruction         = instr_q;
  assign out_instruction_address = wrAddr_q;
  assign out_instruction_write   = (state_q == ST_WR_STROBE);
  assign out_core_reset          = pulseActive;
  assign out_core_running        = (state_q == ST_START);
  assign out_busy                = (state_q != ST_HDR_HI) && (state_q != ST_ERROR);
  assign out_done                = (state_q == ST_DONE);
  assign out_error               = (state_q == ST_ERROR);

endmodule
